// File: rtl/bus_io_mailbox.sv
// I/O-space bus responder with wait-state insertion and a pair of
// 16-bit mailbox FIFOs toward a local device.
module bus_io_mailbox #(
  parameter logic [7:0]  BASE        = 8'h40,
  parameter int unsigned WAIT_STATES = 2,
  parameter int unsigned DEPTH_LOG2  = 3
) (
  input  logic        clk,
  input  logic        nreset,
  input  logic        nsel,
  input  logic        nio,
  input  logic        nr,
  input  logic        nw,
  input  logic [7:0]  ab,
  inout  wire  [15:0] db,
  inout  wire         nws,
  output logic [15:0] out_data,
  output logic        out_valid,
  input  logic        out_ready,
  input  logic [15:0] in_data,
  input  logic        in_valid,
  output logic        in_ready
);

  localparam int AW    = DEPTH_LOG2;
  localparam int PW    = DEPTH_LOG2 + 1;
  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [PW-1:0] FULLC = PW'(DEPTH);
  localparam logic [3:0] WS = WAIT_STATES[3:0];

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_ACK  = 2'd2;
  localparam logic [1:0] S_HOLD = 2'd3;

  logic [1:0]    state_q, state_d;
  logic [3:0]    cnt_q, cnt_d;
  logic [1:0]    reg_q;
  logic          rd_q;
  logic          stale_q;
  logic [15:0]   dout_q;
  logic          ovf_q, ovf_d;

  logic [PW-1:0] tx_wr_q, tx_wr_d, tx_rd_q, tx_rd_d;
  logic [PW-1:0] rx_wr_q, rx_wr_d, rx_rd_q, rx_rd_d;
  logic [15:0]   tx_mem [DEPTH];
  logic [15:0]   rx_mem [DEPTH];

  logic          hit, accept, active;
  logic          in_idle, in_wait, in_ack, in_hold;
  logic          bus_rd, bus_wr;
  logic [PW-1:0] tx_cnt, rx_cnt;
  logic          tx_full, tx_empty, rx_full, rx_empty;
  logic          tx_push_req, tx_push, tx_pop, tx_drop;
  logic          rx_push, rx_pop;
  logic [15:0]   status, rd_word;
  logic          nws_low, db_oe;

  assign in_idle = (state_q == S_IDLE);
  assign in_wait = (state_q == S_WAIT);
  assign in_ack  = (state_q == S_ACK);
  assign in_hold = (state_q == S_HOLD);

  assign hit = !nsel && !nio && (ab[7:2] == BASE[7:2]) && (nr ^ nw);
  // A strobe still low when reset releases must not start a transaction.
  assign accept = in_idle && hit && !stale_q;
  assign active = !nsel && !nio && (rd_q ? !nr : !nw);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          cnt_d   = WS - 4'd1;
          state_d = (WS <= 4'd1) ? S_ACK : S_WAIT;
        end
      end
      S_WAIT: begin
        if (!active) begin
          state_d = S_IDLE;
        end else if (cnt_q <= 4'd1) begin
          state_d = S_ACK;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_ACK:   state_d = active ? S_HOLD : S_IDLE;
      default: state_d = active ? S_HOLD : S_IDLE;
    endcase
  end

  assign tx_cnt   = tx_wr_q - tx_rd_q;
  assign rx_cnt   = rx_wr_q - rx_rd_q;
  assign tx_full  = (tx_cnt == FULLC);
  assign rx_full  = (rx_cnt == FULLC);
  assign tx_empty = (tx_cnt == '0);
  assign rx_empty = (rx_cnt == '0);

  assign bus_rd = in_ack && rd_q;
  assign bus_wr = in_ack && !rd_q;

  // A local pop in the same edge frees the slot, so a full FIFO still
  // accepts the bus write.
  assign tx_pop      = !tx_empty && out_ready;
  assign tx_push_req = bus_wr && (reg_q == 2'd0);
  assign tx_push     = tx_push_req && (!tx_full || tx_pop);
  assign tx_drop     = tx_push_req && tx_full && !tx_pop;

  assign rx_push = in_valid && !rx_full;
  assign rx_pop  = bus_rd && (reg_q == 2'd0) && !rx_empty;

  assign tx_wr_d = tx_wr_q + PW'(tx_push);
  assign tx_rd_d = tx_rd_q + PW'(tx_pop);
  assign rx_wr_d = rx_wr_q + PW'(rx_push);
  assign rx_rd_d = rx_rd_q + PW'(rx_pop);

  always_comb begin
    ovf_d = ovf_q;
    if (tx_drop) begin
      ovf_d = 1'b1;
    end else if (bus_wr && (reg_q == 2'd1) && db[2]) begin
      ovf_d = 1'b0;
    end
  end

  assign status = {8'(rx_cnt), 4'b0000,
                   tx_empty, ovf_q, tx_full, !rx_empty};

  always_comb begin
    rd_word = 16'h0000;
    unique case (1'b1)
      (reg_q == 2'd0): rd_word = rx_empty ? 16'h0000
                                          : rx_mem[rx_rd_q[AW-1:0]];
      (reg_q == 2'd1): rd_word = status;
      default:         rd_word = 16'h0000;
    endcase
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      reg_q   <= 2'd0;
      rd_q    <= 1'b0;
      stale_q <= 1'b1;
      dout_q  <= 16'h0000;
      ovf_q   <= 1'b0;
      tx_wr_q <= '0;
      tx_rd_q <= '0;
      rx_wr_q <= '0;
      rx_rd_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        reg_q <= ab[1:0];
        rd_q  <= !nr;
      end
      if (!hit) stale_q <= 1'b0;
      if (bus_rd) dout_q <= rd_word;
      ovf_q   <= ovf_d;
      tx_wr_q <= tx_wr_d;
      tx_rd_q <= tx_rd_d;
      rx_wr_q <= rx_wr_d;
      rx_rd_q <= rx_rd_d;
    end
  end

  always_ff @(posedge clk) begin
    if (tx_push) tx_mem[tx_wr_q[AW-1:0]] <= db;
    if (rx_push) rx_mem[rx_wr_q[AW-1:0]] <= in_data;
  end

  assign out_data  = tx_empty ? 16'h0000 : tx_mem[tx_rd_q[AW-1:0]];
  assign out_valid = !tx_empty;
  assign in_ready  = !rx_full;

  assign nws_low = in_wait || (accept && (WS != 4'd0));
  assign nws     = nws_low ? 1'b0 : 1'bz;

  // The ACK cycle shows the word being registered; HOLD replays it.
  assign db_oe = rd_q && (in_ack || in_hold);
  assign db    = db_oe ? (in_ack ? rd_word : dout_q) : 16'hzzzz;

endmodule

// File: tb/tb_bus_io_mailbox.sv
// Directed and randomized bench for bus_io_mailbox against a queue model.
// Released bus lines are pulled up, so an idle db reads 0xFFFF.
module tb_bus_io_mailbox;

  logic        clk = 1'b0;
  logic        nreset, nsel, nsel0, nio, nr, nw;
  logic [7:0]  ab;
  logic [15:0] db_drv;
  logic        db_oe;
  logic        out_ready, in_valid;
  logic [15:0] in_data;
  wire  [15:0] db, db0;
  wire         nws, nws0;
  logic [15:0] out_data, out_data0;
  logic        out_valid, out_valid0, in_ready, in_ready0;

  int ntests = 0;
  int nfail  = 0;
  bit use0   = 1'b0;

  logic [15:0] txq[$];
  logic [15:0] rxq[$];
  logic        m_ovf;

  always #5 clk = ~clk;

  assign db  = db_oe ? db_drv : 16'hzzzz;
  assign db0 = db_oe ? db_drv : 16'hzzzz;
  pullup pu_nws (nws);
  pullup pu_nws0 (nws0);
  for (genvar g = 0; g < 16; g++) begin : g_pu
    pullup pa (db[g]);
    pullup pb (db0[g]);
  end

  bus_io_mailbox dut (
    .clk(clk), .nreset(nreset), .nsel(nsel), .nio(nio),
    .nr(nr), .nw(nw), .ab(ab), .db(db), .nws(nws),
    .out_data(out_data), .out_valid(out_valid),
    .out_ready(out_ready), .in_data(in_data),
    .in_valid(in_valid), .in_ready(in_ready)
  );

  bus_io_mailbox #(.WAIT_STATES(0)) u0 (
    .clk(clk), .nreset(nreset), .nsel(nsel0), .nio(nio),
    .nr(nr), .nw(nw), .ab(ab), .db(db0), .nws(nws0),
    .out_data(out_data0), .out_valid(out_valid0),
    .out_ready(1'b0), .in_data(16'h0000),
    .in_valid(1'b0), .in_ready(in_ready0)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    ntests++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] m_status();
    logic [7:0] c;
    c = 8'(rxq.size());
    return {c, 4'b0000, txq.size() == 0, m_ovf,
            txq.size() == 8, rxq.size() != 0};
  endfunction

  function automatic void m_write(input logic [1:0] r,
                                  input logic [15:0] d);
    if (r == 2'd0) begin
      if (txq.size() < 8) txq.push_back(d);
      else m_ovf = 1'b1;
    end else if (r == 2'd1 && d[2]) begin
      m_ovf = 1'b0;
    end
  endfunction

  function automatic logic [15:0] m_read(input logic [1:0] r);
    if (r == 2'd0) return (rxq.size() != 0) ? rxq.pop_front() : 16'h0000;
    if (r == 2'd1) return m_status();
    return 16'h0000;
  endfunction

  task automatic access(input bit rd, input bit both, input bit desel,
                        input logic [7:0] a, input logic [15:0] wd,
                        input int cyc, input int popc,
                        output logic [15:0] rdat, output int nlow,
                        output int fdrv, output logic [15:0] dbend);
    logic [15:0] dbs;
    nlow = 0;
    fdrv = -1;
    rdat = 16'hFFFF;
    ab = a;
    nio = 1'b0;
    if (use0) nsel0 = desel;
    else nsel = desel;
    nr = !(rd || both);
    nw = !(!rd || both);
    db_drv = wd;
    db_oe = !rd && !both;
    for (int i = 0; i < cyc; i++) begin
      out_ready = (i == popc);
      @(negedge clk);
      dbs = use0 ? db0 : db;
      if ((use0 ? nws0 : nws) === 1'b0) nlow++;
      if (!db_oe && dbs !== 16'hFFFF && fdrv < 0) begin
        fdrv = i;
        rdat = dbs;
      end
      @(posedge clk);
      #1;
    end
    out_ready = 1'b0;
    nio = 1'b1; nr = 1'b1; nw = 1'b1;
    nsel = 1'b1; nsel0 = 1'b1; db_oe = 1'b0;
    dbend = 16'h0000;
    for (int j = 0; j < 2; j++) begin
      @(negedge clk);
      if ((use0 ? nws0 : nws) === 1'b0) nlow++;
      if (j == 1) dbend = use0 ? db0 : db;
      @(posedge clk);
      #1;
    end
  endtask

  task automatic lpush(input logic [15:0] v);
    chk("in_ready", {31'd0, in_ready}, {31'd0, rxq.size() < 8});
    in_data = v;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    if (rxq.size() < 8) rxq.push_back(v);
  endtask

  task automatic lpop();
    chk("out_valid", {31'd0, out_valid}, {31'd0, txq.size() != 0});
    if (txq.size() != 0) chk("out_data", {16'd0, out_data}, {16'd0, txq[0]});
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    if (txq.size() != 0) void'(txq.pop_front());
  endtask

  task automatic bwrite(input logic [7:0] a, input logic [15:0] d);
    logic [15:0] r, e;
    int nl, fd;
    access(1'b0, 1'b0, 1'b0, a, d, 4, -1, r, nl, fd, e);
    chk("wr_nws_low", nl, 2);
    m_write(a[1:0], d);
  endtask

  task automatic bread(input logic [7:0] a, input string tag);
    logic [15:0] r, e, x;
    int nl, fd;
    x = m_read(a[1:0]);
    access(1'b1, 1'b0, 1'b0, a, 16'h0000, 4, -1, r, nl, fd, e);
    chk(tag, {16'd0, r}, {16'd0, x});
    chk("rd_ack_cycle", fd, 2);
    chk("rd_nws_low", nl, 2);
    chk("rd_db_release", {16'd0, e}, 32'h0000FFFF);
  endtask

  initial begin
    logic [15:0] r, e, v;
    int nl, fd, zc;
    nreset = 1'b0;
    nsel = 1'b1; nsel0 = 1'b1; nio = 1'b1; nr = 1'b1; nw = 1'b1;
    ab = 8'h00; db_drv = 16'h0000; db_oe = 1'b0;
    out_ready = 1'b0; in_valid = 1'b0; in_data = 16'h0000;
    m_ovf = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", {31'd0, out_valid}, 0);
    chk("rst_out_data", {16'd0, out_data}, 0);
    chk("rst_in_ready", {31'd0, in_ready}, 1);
    chk("rst_db", {16'd0, db}, 32'h0000FFFF);
    chk("rst_nws", {31'd0, nws}, 1);
    nreset = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    bwrite(8'h40, 16'h1234);
    chk("tx_valid", {31'd0, out_valid}, 1);
    chk("tx_head", {16'd0, out_data}, 32'h1234);
    lpop();
    chk("tx_drained", {31'd0, out_valid}, 0);

    lpush(16'hBEEF);
    lpush(16'h0001);
    bread(8'h41, "status_two_rx");
    bread(8'h40, "rx_pop1");
    bread(8'h40, "rx_pop2");
    bread(8'h40, "rx_empty_read");
    bread(8'h41, "status_empty");
    bread(8'h42, "reserved_rd");

    for (int i = 0; i < 9; i++) bwrite(8'h40, 16'h1000 + 16'(i));
    bread(8'h41, "status_ovf");
    bwrite(8'h43, 16'hFFFE);
    bwrite(8'h41, 16'h0004);
    bread(8'h41, "status_ovf_clr");

    // Full TX: bus push and local pop land on the same edge.
    access(1'b0, 1'b0, 1'b0, 8'h40, 16'h5A5A, 4, 2, r, nl, fd, e);
    void'(txq.pop_front());
    m_write(2'd0, 16'h5A5A);
    bread(8'h41, "status_coincide");
    for (int i = 0; i < 8; i++) lpop();

    access(1'b0, 1'b0, 1'b0, 8'h40, 16'h7777, 1, -1, r, nl, fd, e);
    chk("abort_wr_nws", nl, 2);
    chk("abort_wr_nws_rel", {16'd0, e}, 32'h0000FFFF);
    chk("abort_wr_notx", {31'd0, out_valid}, 0);
    lpush(16'h4321);
    access(1'b1, 1'b0, 1'b0, 8'h40, 16'h0000, 1, -1, r, nl, fd, e);
    chk("abort_rd_nodrv", fd, -1);
    bread(8'h41, "status_abort");

    access(1'b1, 1'b0, 1'b0, 8'h44, 16'h0000, 4, -1, r, nl, fd, e);
    chk("miss_addr_nws", nl, 0);
    chk("miss_addr_db", fd, -1);
    access(1'b0, 1'b0, 1'b0, 8'h44, 16'h2222, 4, -1, r, nl, fd, e);
    chk("miss_addr_wr", {31'd0, out_valid}, 0);
    access(1'b1, 1'b0, 1'b1, 8'h40, 16'h0000, 4, -1, r, nl, fd, e);
    chk("miss_nsel_nws", nl, 0);
    chk("miss_nsel_db", fd, -1);
    access(1'b1, 1'b1, 1'b0, 8'h40, 16'h0000, 4, -1, r, nl, fd, e);
    chk("miss_both_nws", nl, 0);
    chk("miss_both_db", fd, -1);
    bread(8'h41, "status_after_miss");

    for (int i = 0; i < 40; i++) begin
      v = 16'($urandom_range(0, 16'hFFFE));
      case ($urandom_range(0, 5))
        0: bwrite(8'h40, v);
        1: bread(8'h40, "rnd_rx");
        2: bread(8'h41, "rnd_status");
        3: bwrite(8'h41, v & 16'h0004);
        4: lpush(v);
        default: lpop();
      endcase
      chk("rnd_out_valid", {31'd0, out_valid}, {31'd0, txq.size() != 0});
    end

    use0 = 1'b1;
    access(1'b1, 1'b0, 1'b0, 8'h41, 16'h0000, 4, -1, r, nl, fd, e);
    chk("ws0_nws", nl, 0);
    chk("ws0_ack_cycle", fd, 1);
    chk("ws0_status", {16'd0, r}, 32'h0008);
    access(1'b0, 1'b0, 1'b0, 8'h40, 16'h7A7A, 4, -1, r, nl, fd, e);
    chk("ws0_wr_nws", nl, 0);
    chk("ws0_tx_data", {16'd0, out_data0}, 32'h7A7A);
    use0 = 1'b0;

    lpush(16'h0CAF);
    ab = 8'h40; nsel = 1'b0; nio = 1'b0; nr = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    chk("hold_db", {16'd0, db}, 32'h0CAF);
    nreset = 1'b0;
    #2;
    chk("rst_hold_db", {16'd0, db}, 32'h0000FFFF);
    chk("rst_hold_nws", {31'd0, nws}, 1);
    chk("rst_hold_tx", {31'd0, out_valid}, 0);
    chk("rst_hold_rx", {31'd0, in_ready}, 1);
    @(posedge clk);
    #1;
    nreset = 1'b1;
    zc = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (nws === 1'b0 || db !== 16'hFFFF) zc++;
    end
    chk("stale_strobe_ignored", zc, 0);
    @(posedge clk);
    #1;
    nio = 1'b1; nr = 1'b1; nsel = 1'b1;
    txq.delete();
    rxq.delete();
    m_ovf = 1'b0;
    @(posedge clk);
    #1;
    bread(8'h41, "status_post_rst");

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
